firebird7_in_gate1_tessent_data_mux_hold: RTL and testbench
===========================================================

# firebird7_in_gate1_tessent_data_mux_hold

Parametrised, multi-channel IJTAG override mux for the firebird7_in gate1 instrument network. Each channel selects between functional data and IJTAG-driven data through a registered, per-channel state machine. The state machine inserts a programmable number of hold cycles on every handover, so the downstream logic never sees a same-cycle mix of sources. The block also provides a capture register that snapshots functional data for IJTAG read-back. It sits between the SIB/TDR-controlled select bits and the functional logic they override.

## Interface
- WIDTH, 3, data bits per channel (>=1)
- NUM_CH, 4, number of independent channels (>=1)
- HOLD_CYCLES, 2, edges data_out is frozen on each handover (0..15; 0 = direct switch)

- ijtag_tck  in  1  clock; all state updates on rising edge
- ijtag_reset  in  1  asynchronous, active-low reset
- ijtag_select  in  NUM_CH  per-channel override request (1 = IJTAG source)
- ijtag_data_in  in  NUM_CH*WIDTH  IJTAG data; channel c at bits [c*WIDTH +: WIDTH]
- functional_data_in  in  NUM_CH*WIDTH  functional data, same packing
- ijtag_capture_en  in  1  snapshot functional_data_in into capture_data
- data_out  out  NUM_CH*WIDTH  registered muxed output, same packing
- capture_data  out  NUM_CH*WIDTH  captured functional data
- sel_active  out  NUM_CH  channel currently driving IJTAG data
- switch_busy  out  NUM_CH  channel in a hold state

## Operation
- Each channel has an independent FSM with states FUNC, HOLD_TO_IJTAG, IJTAG and HOLD_TO_FUNC.
- Each channel has a 4-bit hold counter cnt.
- FUNC:
  - ijtag_select[c]=1 with HOLD_CYCLES=0 -> IJTAG.
  - ijtag_select[c]=1 with HOLD_CYCLES>0 -> HOLD_TO_IJTAG, cnt<=HOLD_CYCLES-1.
  - Otherwise the channel stays in FUNC.
- HOLD_TO_IJTAG:
  - ijtag_select[c]=0 -> HOLD_TO_FUNC, cnt<=HOLD_CYCLES-1. This is an abort; the hold restarts with full length.
  - Else if cnt==0 -> IJTAG.
  - Else cnt<=cnt-1.
- IJTAG and HOLD_TO_FUNC mirror FUNC and HOLD_TO_IJTAG with the select polarity inverted.
- data_out per channel is driven by the next state:
  - FUNC -> functional_data_in.
  - IJTAG -> ijtag_data_in.
  - Either hold state -> previous data_out value.
- sel_active[c] = (state==IJTAG). switch_busy[c] = state is either hold. Both decode from the state registers with no added latency.
- Capture: ijtag_capture_en=1 at an edge -> capture_data <= functional_data_in for all channels, independent of FSM state. Otherwise capture_data holds.
- Channels never interact. Any mix of simultaneous switches is legal.

## Timing
- Reset (ijtag_reset=0, asynchronous) forces every output to its reset value immediately, including mid-hold:
  - all FSMs -> FUNC, cnt=0
  - data_out=0, capture_data=0, sel_active=0, switch_busy=0
- After reset deassertion, the first rising edge performs normal FUNC behaviour.
- With HOLD_CYCLES=0: select sampled high at edge N -> data_out = ijtag_data_in sampled at N, and sel_active=1 after N.
- With HOLD_CYCLES=H>0: select sampled high at edge N:
  - data_out frozen at edges N..N+H-1
  - switch_busy=1 after edges N..N+H-1
  - edge N+H loads ijtag_data_in, and sel_active=1 after N+H
- The reverse direction has identical timing.
- Abort at edge M inside a hold restarts with a full H-edge hold toward the opposite source. data_out stays frozen throughout.
- Steady state (FUNC or IJTAG) has 1-cycle latency from the selected input to data_out.
- A select pulse shorter than one cycle that is not sampled on an edge has no effect.

## Test plan
- Reset/default: assert ijtag_reset=0 mid-hold with data_out=3'b101 -> all outputs 0 immediately. After release with select=0 and functional=3'b110 on ch0, data_out[2:0]=3'b110 one edge later.
- Handover H=2: ch1 functional=3'b011, ijtag=3'b100, select rises before edge N:
  - data_out[5:3]=3'b011 at N and N+1, with switch_busy[1]=1
  - 3'b100 at N+2, with sel_active[1]=1 and switch_busy[1]=0
- Abort: select high at edge N, low at edge N+1 (H=2) -> HOLD_TO_FUNC restarts, data_out frozen at edges N..N+2, functional data reappears at edge N+3, and sel_active never rises.
- Direct switch H=0: toggle ch2 select every cycle -> data_out[8:6] alternates source each edge, and switch_busy stays 0.
- Independence: switch ch0 to IJTAG and ch3 back to FUNC on the same edge -> both complete after H edges; ch1 and ch2 data_out keep tracking their functional inputs unaffected.
- Capture: functional_data_in=12'hA5C, pulse ijtag_capture_en for one edge while ch0 is IJTAG-selected -> capture_data=12'hA5C and is held after functional input changes. data_out is unaffected.

Source files
------------

// File: rtl/firebird7_in_gate1_tessent_data_mux_hold_if.sv
// Bus bundle for the firebird7_in gate1 IJTAG override mux: select bits, both
// data sources, capture strobe, and the muxed/captured/status outputs.
interface firebird7_in_gate1_tessent_data_mux_hold_if #(
    parameter int WIDTH  = 3,
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0]       ijtag_select;
    logic [NUM_CH*WIDTH-1:0] ijtag_data_in;
    logic [NUM_CH*WIDTH-1:0] functional_data_in;
    logic                    ijtag_capture_en;
    logic [NUM_CH*WIDTH-1:0] data_out;
    logic [NUM_CH*WIDTH-1:0] capture_data;
    logic [NUM_CH-1:0]       sel_active;
    logic [NUM_CH-1:0]       switch_busy;

    modport master (
        output ijtag_select, ijtag_data_in, functional_data_in, ijtag_capture_en,
        input  data_out, capture_data, sel_active, switch_busy
    );

    modport slave (
        input  ijtag_select, ijtag_data_in, functional_data_in, ijtag_capture_en,
        output data_out, capture_data, sel_active, switch_busy
    );
endinterface

// File: rtl/firebird7_in_gate1_tessent_data_mux_hold.sv
// Per-channel IJTAG/functional override mux with a programmable frozen-output
// hold on every handover, plus a functional-data capture register.
module firebird7_in_gate1_tessent_data_mux_hold #(
    parameter int WIDTH       = 3,
    parameter int NUM_CH      = 4,
    parameter int HOLD_CYCLES = 2
) (
    input logic ijtag_tck,
    input logic ijtag_reset,
    firebird7_in_gate1_tessent_data_mux_hold_if.slave bus
);
    typedef enum logic [1:0] {
        FUNC,
        HOLD_TO_IJTAG,
        IJTAG,
        HOLD_TO_FUNC
    } state_e;

    localparam bit         DIRECT      = (HOLD_CYCLES == 0);
    localparam logic [3:0] HOLD_RELOAD = DIRECT ? 4'd0 : 4'(HOLD_CYCLES - 1);

    state_e                  state_q [NUM_CH];
    state_e                  state_d [NUM_CH];
    logic [3:0]              cnt_q   [NUM_CH];
    logic [3:0]              cnt_d   [NUM_CH];
    logic [NUM_CH*WIDTH-1:0] data_out_q, data_out_d;
    logic [NUM_CH*WIDTH-1:0] capture_data_q, capture_data_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        data_out_d     = data_out_q;
        capture_data_d = bus.ijtag_capture_en ? bus.functional_data_in : capture_data_q;
        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            unique case (state_q[c])
                FUNC: begin
                    if (bus.ijtag_select[c]) begin
                        if (DIRECT) begin
                            state_d[c] = IJTAG;
                        end else begin
                            state_d[c] = HOLD_TO_IJTAG;
                            cnt_d[c]   = HOLD_RELOAD;
                        end
                    end
                end
                HOLD_TO_IJTAG: begin
                    // A dropped request aborts and restarts a full-length hold back.
                    if (!bus.ijtag_select[c]) begin
                        state_d[c] = HOLD_TO_FUNC;
                        cnt_d[c]   = HOLD_RELOAD;
                    end else if (cnt_q[c] == 4'd0) begin
                        state_d[c] = IJTAG;
                    end else begin
                        cnt_d[c] = cnt_q[c] - 4'd1;
                    end
                end
                IJTAG: begin
                    if (!bus.ijtag_select[c]) begin
                        if (DIRECT) begin
                            state_d[c] = FUNC;
                        end else begin
                            state_d[c] = HOLD_TO_FUNC;
                            cnt_d[c]   = HOLD_RELOAD;
                        end
                    end
                end
                HOLD_TO_FUNC: begin
                    if (bus.ijtag_select[c]) begin
                        state_d[c] = HOLD_TO_IJTAG;
                        cnt_d[c]   = HOLD_RELOAD;
                    end else if (cnt_q[c] == 4'd0) begin
                        state_d[c] = FUNC;
                    end else begin
                        cnt_d[c] = cnt_q[c] - 4'd1;
                    end
                end
            endcase

            // The output follows the state being entered, so a hold freezes it on the same edge.
            case (state_d[c])
                FUNC:    data_out_d[c*WIDTH +: WIDTH] = bus.functional_data_in[c*WIDTH +: WIDTH];
                IJTAG:   data_out_d[c*WIDTH +: WIDTH] = bus.ijtag_data_in[c*WIDTH +: WIDTH];
                default: data_out_d[c*WIDTH +: WIDTH] = data_out_q[c*WIDTH +: WIDTH];
            endcase
        end
    end

    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= FUNC;
                cnt_q[c]   <= 4'd0;
            end
            data_out_q     <= '0;
            capture_data_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
            end
            data_out_q     <= data_out_d;
            capture_data_q <= capture_data_d;
        end
    end

    always_comb begin
        bus.sel_active  = '0;
        bus.switch_busy = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            bus.sel_active[c]  = (state_q[c] == IJTAG);
            bus.switch_busy[c] = (state_q[c] == HOLD_TO_IJTAG) || (state_q[c] == HOLD_TO_FUNC);
        end
    end

    assign bus.data_out     = data_out_q;
    assign bus.capture_data = capture_data_q;
endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_hold.sv
// Directed plus randomized bench for the override mux; two instances (hold 2 and
// hold 0) share stimulus and are scored against a source-ownership model.
module tb_firebird7_in_gate1_tessent_data_mux_hold;
    localparam int W  = 3;
    localparam int NC = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NC-1:0]   sel  = '0;
    logic [NC*W-1:0] idat = '0;
    logic [NC*W-1:0] fdat = '0;
    logic            cap  = 1'b0;

    firebird7_in_gate1_tessent_data_mux_hold_if #(.WIDTH(W), .NUM_CH(NC)) if_h2 ();
    firebird7_in_gate1_tessent_data_mux_hold_if #(.WIDTH(W), .NUM_CH(NC)) if_h0 ();

    assign if_h2.ijtag_select       = sel;
    assign if_h2.ijtag_data_in      = idat;
    assign if_h2.functional_data_in = fdat;
    assign if_h2.ijtag_capture_en   = cap;
    assign if_h0.ijtag_select       = sel;
    assign if_h0.ijtag_data_in      = idat;
    assign if_h0.functional_data_in = fdat;
    assign if_h0.ijtag_capture_en   = cap;

    firebird7_in_gate1_tessent_data_mux_hold #(.WIDTH(W), .NUM_CH(NC), .HOLD_CYCLES(2)) dut_h2 (
        .ijtag_tck(clk), .ijtag_reset(rst_n), .bus(if_h2));
    firebird7_in_gate1_tessent_data_mux_hold #(.WIDTH(W), .NUM_CH(NC), .HOLD_CYCLES(0)) dut_h0 (
        .ijtag_tck(clk), .ijtag_reset(rst_n), .bus(if_h0));

    int total = 0;
    int bad   = 0;

    // Model: which source owns each output, how many frozen edges remain, and where the hold leads.
    int         hold_len [2] = '{2, 0};
    int         owner    [2][NC];
    int         pend     [2][NC];
    int         tgt      [2][NC];
    logic [W-1:0] mout   [2][NC];
    logic [NC*W-1:0] mcap;

    function automatic logic [W-1:0] src(int s, int c);
        return (s != 0) ? idat[c*W +: W] : fdat[c*W +: W];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < NC; c++) begin
                owner[i][c] = 0; pend[i][c] = 0; tgt[i][c] = 0; mout[i][c] = '0;
            end
        mcap = '0;
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < NC; c++) begin
                int want;
                want = sel[c] ? 1 : 0;
                if (pend[i][c] == 0) begin
                    if (want != owner[i][c]) begin
                        if (hold_len[i] == 0) begin
                            owner[i][c] = want;
                            mout[i][c]  = src(want, c);
                        end else begin
                            tgt[i][c]  = want;
                            pend[i][c] = hold_len[i];
                        end
                    end else begin
                        mout[i][c] = src(owner[i][c], c);
                    end
                end else if (want != tgt[i][c]) begin
                    tgt[i][c]  = want;
                    pend[i][c] = hold_len[i];
                end else begin
                    pend[i][c]--;
                    if (pend[i][c] == 0) begin
                        owner[i][c] = tgt[i][c];
                        mout[i][c]  = src(owner[i][c], c);
                    end
                end
            end
        if (cap) mcap = fdat;
    endtask

    function automatic logic [NC*W-1:0] exp_dout(int i);
        logic [NC*W-1:0] v;
        for (int c = 0; c < NC; c++) v[c*W +: W] = mout[i][c];
        return v;
    endfunction

    function automatic logic [NC-1:0] exp_sel(int i);
        logic [NC-1:0] v;
        for (int c = 0; c < NC; c++) v[c] = (pend[i][c] == 0) && (owner[i][c] == 1);
        return v;
    endfunction

    function automatic logic [NC-1:0] exp_busy(int i);
        logic [NC-1:0] v;
        for (int c = 0; c < NC; c++) v[c] = (pend[i][c] > 0);
        return v;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(string tag);
        check({tag, ":h2.dout"}, 32'(if_h2.data_out),    32'(exp_dout(0)));
        check({tag, ":h2.act"},  32'(if_h2.sel_active),  32'(exp_sel(0)));
        check({tag, ":h2.busy"}, 32'(if_h2.switch_busy), 32'(exp_busy(0)));
        check({tag, ":h2.cap"},  32'(if_h2.capture_data), 32'(mcap));
        check({tag, ":h0.dout"}, 32'(if_h0.data_out),    32'(exp_dout(1)));
        check({tag, ":h0.act"},  32'(if_h0.sel_active),  32'(exp_sel(1)));
        check({tag, ":h0.busy"}, 32'(if_h0.switch_busy), 32'(exp_busy(1)));
        check({tag, ":h0.cap"},  32'(if_h0.capture_data), 32'(mcap));
    endtask

    task automatic step(string tag);
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [W-1:0] e3;
        model_reset();
        #3;
        check_all("reset0");
        #4 rst_n = 1'b1;

        // Reset asserted mid-hold clears everything immediately.
        fdat[2:0] = 3'b101;
        step("pre_hold");
        check("pre_hold.ch0", 32'(if_h2.data_out[2:0]), 32'(3'b101));
        sel[0] = 1'b1;
        step("in_hold");
        check("in_hold.busy0", 32'(if_h2.switch_busy[0]), 32'd1);
        check("in_hold.ch0", 32'(if_h2.data_out[2:0]), 32'(3'b101));
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        check("async_rst.dout", 32'(if_h2.data_out), 32'd0);
        check("async_rst.busy", 32'(if_h2.switch_busy), 32'd0);
        #2 rst_n = 1'b1;
        sel = '0;
        fdat[2:0] = 3'b110;
        step("post_rst");
        check("post_rst.ch0", 32'(if_h2.data_out[2:0]), 32'(3'b110));

        // Handover on ch1 with a 2-edge hold.
        fdat[5:3] = 3'b011;
        idat[5:3] = 3'b100;
        step("ho_pre");
        sel[1] = 1'b1;
        step("ho_n");
        check("ho_n.ch1", 32'(if_h2.data_out[5:3]), 32'(3'b011));
        check("ho_n.busy1", 32'(if_h2.switch_busy[1]), 32'd1);
        fdat[5:3] = 3'b010;
        step("ho_n1");
        check("ho_n1.ch1", 32'(if_h2.data_out[5:3]), 32'(3'b011));
        check("ho_n1.busy1", 32'(if_h2.switch_busy[1]), 32'd1);
        step("ho_n2");
        check("ho_n2.ch1", 32'(if_h2.data_out[5:3]), 32'(3'b100));
        check("ho_n2.act1", 32'(if_h2.sel_active[1]), 32'd1);
        check("ho_n2.busy1", 32'(if_h2.switch_busy[1]), 32'd0);

        // Abort on ch2: request drops one edge into the hold.
        fdat[8:6] = 3'b001;
        idat[8:6] = 3'b110;
        step("ab_pre");
        sel[2] = 1'b1;
        step("ab_n");
        check("ab_n.ch2", 32'(if_h2.data_out[8:6]), 32'(3'b001));
        sel[2] = 1'b0;
        fdat[8:6] = 3'b010;
        step("ab_n1");
        check("ab_n1.ch2", 32'(if_h2.data_out[8:6]), 32'(3'b001));
        check("ab_n1.busy2", 32'(if_h2.switch_busy[2]), 32'd1);
        step("ab_n2");
        check("ab_n2.ch2", 32'(if_h2.data_out[8:6]), 32'(3'b001));
        check("ab_n2.act2", 32'(if_h2.sel_active[2]), 32'd0);
        step("ab_n3");
        check("ab_n3.ch2", 32'(if_h2.data_out[8:6]), 32'(3'b010));
        check("ab_n3.act2", 32'(if_h2.sel_active[2]), 32'd0);
        check("ab_n3.busy2", 32'(if_h2.switch_busy[2]), 32'd0);

        // Direct switching on the hold-0 instance: ch2 alternates source each edge.
        for (int k = 0; k < 6; k++) begin
            sel[2] = ~sel[2];
            fdat[8:6] = 3'(k);
            idat[8:6] = ~3'(k);
            e3 = sel[2] ? ~3'(k) : 3'(k);
            step("dir");
            check("dir.ch2", 32'(if_h0.data_out[8:6]), 32'(e3));
            check("dir.busy", 32'(if_h0.switch_busy), 32'd0);
        end
        sel = '0;
        step("settle0"); step("settle1"); step("settle2");

        // Simultaneous opposite switches on ch0 and ch3; ch1/ch2 keep tracking.
        sel[3] = 1'b1;
        step("ind_pre0"); step("ind_pre1"); step("ind_pre2");
        sel[0] = 1'b1;
        sel[3] = 1'b0;
        idat[2:0]  = 3'b011;
        fdat[11:9] = 3'b100;
        for (int k = 0; k < 3; k++) begin
            fdat[5:3] = 3'(k + 1);
            fdat[8:6] = 3'(6 - k);
            step("ind");
            check("ind.ch1", 32'(if_h2.data_out[5:3]), 32'(k + 1));
            check("ind.ch2", 32'(if_h2.data_out[8:6]), 32'(6 - k));
            if (k < 2) check("ind.busy", 32'(if_h2.switch_busy), 32'(4'b1001));
        end
        check("ind.act", 32'(if_h2.sel_active), 32'(4'b0001));
        check("ind.busy_end", 32'(if_h2.switch_busy), 32'd0);
        check("ind.ch0", 32'(if_h2.data_out[2:0]), 32'(3'b011));
        check("ind.ch3", 32'(if_h2.data_out[11:9]), 32'(3'b100));

        // Capture while ch0 is IJTAG-selected.
        fdat = 12'hA5C;
        cap  = 1'b1;
        step("cap");
        cap = 1'b0;
        check("cap.val", 32'(if_h2.capture_data), 32'h0000_0A5C);
        check("cap.ch0", 32'(if_h2.data_out[2:0]), 32'(3'b011));
        fdat = 12'h123;
        step("cap_hold");
        check("cap_hold.val", 32'(if_h2.capture_data), 32'h0000_0A5C);
        check("cap_hold.ch0", 32'(if_h2.data_out[2:0]), 32'(3'b011));

        // Random traffic with occasional asynchronous reset between edges.
        for (int n = 0; n < 400; n++) begin
            sel  = sel ^ NC'($urandom & $urandom);
            idat = (NC*W)'($urandom);
            fdat = (NC*W)'($urandom);
            cap  = ($urandom_range(0, 7) == 0);
            step("rnd");
            if (n % 97 == 50) begin
                #2 rst_n = 1'b0;
                model_reset();
                #1;
                check_all("rnd_rst");
                #1 rst_n = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
